// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-issue instruction fetch unit. Holds the PC, fetches one word at a
// time from instruction memory with a request/grant/response handshake, and
// presents the registered instruction (plus its opcode field and PC+4) to the
// control decoder. Jump/Branch results for the held instruction come back
// from decode and select the next PC when the instruction is consumed.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   IMemReq        - fetch request, held high until granted
//   IMemAddr       - fetch address (the PC), word aligned
//   IMemGnt        - memory accepted the request (honoured only in REQ)
//   IMemRvalid     - read data valid (honoured only in WAIT)
//   IMemRdata      - read data
//   Instr/Opcode   - held instruction and its [31:26] field
//   InstrValid     - Instr/Opcode/PCPlus4 are valid
//   InstrReady     - decode consumes the instruction when InstrValid is high
//   PCPlus4        - PC + 4 of the held instruction
//   Jump, Branch, Zero, BranchOffset - redirect controls, sampled on consume
//   FetchCount     - instructions consumed since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRvalid,
    input  logic [31:0] IMemRdata,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] PCPlus4,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] BranchOffset,
    output logic [31:0] FetchCount
);

    // S_IDLE exists only so that IMemReq is low while reset is asserted and
    // the first request appears one edge after reset is released.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic        r_req;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_offset_x4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4      = r_pc + 32'd4;
    // Bits shifted out of the top of the offset are intentionally discarded.
    assign w_offset_x4     = BranchOffset << 2;
    assign w_jump_target   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_offset_x4;

    // Jump has priority over a taken branch.
    always_comb begin
        // NOTE: the default assignment first guarantees every path drives
        // w_next_pc, so no latch can be inferred.
        w_next_pc = w_pc_plus4;
        if (Jump) begin
            w_next_pc = w_jump_target;
        end else if (Branch && Zero) begin
            w_next_pc = w_branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_count <= 32'd0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (IMemGnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (IMemRvalid) begin
                        r_state <= S_HOLD;
                        r_instr <= IMemRdata;
                        r_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (InstrReady) begin
                        r_state <= S_REQ;
                        r_pc    <= w_next_pc;
                        r_count <= r_count + 32'd1;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign IMemReq    = r_req;
    assign IMemAddr   = r_pc;
    assign Instr      = r_instr;
    assign Opcode     = r_instr[31:26];
    assign InstrValid = r_valid;
    assign PCPlus4    = w_pc_plus4;
    assign FetchCount = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A behavioural model tracks the architectural
// PC, the consume count and the instruction the memory delivered; a compare
// process checks the DUT against it every cycle out of reset. Directed tasks
// drive the memory and decode handshakes and pin literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt = 1'b0;
    logic        IMemRvalid = 1'b0;
    logic [31:0] IMemRdata = 32'd0;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] PCPlus4;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] BranchOffset = 32'd0;
    logic [31:0] FetchCount;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemGnt      (IMemGnt),
        .IMemRvalid   (IMemRvalid),
        .IMemRdata    (IMemRdata),
        .Instr        (Instr),
        .Opcode       (Opcode),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .PCPlus4      (PCPlus4),
        .Jump         (Jump),
        .Branch       (Branch),
        .Zero         (Zero),
        .BranchOffset (BranchOffset),
        .FetchCount   (FetchCount)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_count = 32'd0;
    logic [31:0] m_instr = 32'd0;

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                                  input logic j, input logic b, input logic z,
                                                  input logic [31:0] off);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (j) return {seq[31:28], ins[25:0], 2'b00};
        if (b && z) return seq + off * 32'd4;
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= RESET_PC;
            m_count <= 32'd0;
        end else if (InstrValid && InstrReady) begin
            m_pc    <= model_next_pc(m_pc, m_instr, Jump, Branch, Zero, BranchOffset);
            m_count <= m_count + 32'd1;
        end
    end

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_addr", IMemAddr, m_pc);
            check("model_pcplus4", PCPlus4, m_pc + 32'd4);
            check("model_count", FetchCount, m_count);
            if (InstrValid) begin
                check("model_instr", Instr, m_instr);
                check("model_opcode", 32'(Opcode), 32'(m_instr[31:26]));
                check("model_no_req_in_hold", 32'(IMemReq), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed tasks (all called on a falling edge, return on a falling edge)
    // ------------------------------------------------------------------
    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!IMemReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", 32'(IMemReq), 32'd1);
        check("fetch_addr", IMemAddr, exp_addr);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int gnt_delay);
        wait_req(addr);
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            check("req_held", 32'(IMemReq), 32'd1);
            check("addr_held", IMemAddr, addr);
        end
        IMemGnt = 1'b1;
        @(negedge clk);
        IMemGnt    = 1'b0;
        IMemRdata  = data;
        IMemRvalid = 1'b1;
        m_instr    = data;
        @(negedge clk);
        IMemRvalid = 1'b0;
        check("valid_after_rvalid", 32'(InstrValid), 32'd1);
        check("instr_latched", Instr, data);
    endtask

    task automatic consume(input logic j, input logic b, input logic z, input logic [31:0] off,
                           input logic [31:0] exp_pc);
        Jump = j; Branch = b; Zero = z; BranchOffset = off; InstrReady = 1'b1;
        @(negedge clk);
        InstrReady = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; BranchOffset = 32'd0;
        check("valid_dropped", 32'(InstrValid), 32'd0);
        check("req_after_consume", 32'(IMemReq), 32'd1);
        check("next_pc", IMemAddr, exp_pc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(IMemReq), 32'd0);
        check("rst_addr", IMemAddr, RESET_PC);
        check("rst_instr", Instr, 32'd0);
        check("rst_opcode", 32'(Opcode), 32'd0);
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_pcplus4", PCPlus4, RESET_PC + 32'd4);
        check("rst_count", FetchCount, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_after_edge0", 32'(IMemReq), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // 1. Immediate grant, next-cycle response, decode always ready.
        do_reset();
        InstrReady = 1'b1;
        fetch(32'h0, 32'h2008_0005, 0);
        check("t1_opcode", 32'(Opcode), 32'h08);
        check("t1_pcplus4", PCPlus4, 32'h4);
        @(negedge clk);
        InstrReady = 1'b0;
        check("t1_valid_one_cycle", 32'(InstrValid), 32'd0);
        check("t1_next_addr", IMemAddr, 32'h4);
        check("t1_count", FetchCount, 32'd1);
        check("t1_req", 32'(IMemReq), 32'd1);

        // 2. Sequential stream with delayed grants.
        do_reset();
        fetch(32'h0, 32'h0000_0020, 2); consume(0, 0, 0, 32'd0, 32'h4);
        fetch(32'h4, 32'h0000_0020, 2); consume(0, 0, 0, 32'd0, 32'h8);
        fetch(32'h8, 32'h0000_0020, 2); consume(0, 0, 0, 32'd0, 32'hC);
        fetch(32'hC, 32'h0000_0020, 2); consume(0, 0, 0, 32'd0, 32'h10);

        // 3. Backward taken branch, then the same branch not taken.
        fetch(32'h10, 32'h1000_FFFE, 0); consume(0, 1, 1, 32'hFFFF_FFFE, 32'hC);
        fetch(32'hC, 32'h0000_0020, 1);  consume(0, 0, 0, 32'd0, 32'h10);
        fetch(32'h10, 32'h1000_FFFE, 0); consume(0, 1, 0, 32'hFFFF_FFFE, 32'h14);

        // Far branch to 0x1000_0000: 0x18 + 0x03FF_FFFA*4.
        fetch(32'h14, 32'h1000_0000, 0); consume(0, 1, 1, 32'h03FF_FFFA, 32'h1000_0000);

        // 4. Jump and branch together: jump wins.
        fetch(32'h1000_0000, 32'h0800_0040, 0);
        consume(1, 1, 1, 32'd4, 32'h1000_0100);

        // 5. Decode stalls for 5 cycles with stray handshake inputs.
        fetch(32'h1000_0100, 32'h2009_0001, 0);
        for (int i = 0; i < 5; i++) begin
            IMemRvalid = (i == 1 || i == 2);
            IMemRdata  = 32'hDEAD_BEEF;
            IMemGnt    = (i == 3);
            @(negedge clk);
            check("stall_valid", 32'(InstrValid), 32'd1);
            check("stall_instr", Instr, 32'h2009_0001);
            check("stall_pcplus4", PCPlus4, 32'h1000_0104);
            check("stall_no_req", 32'(IMemReq), 32'd0);
        end
        IMemRvalid = 1'b0;
        IMemGnt    = 1'b0;
        // Offset upper bits are shifted out: 0xFBFF_FFBE*4 mod 2^32 = 0xEFFF_FEF8.
        consume(0, 1, 1, 32'hFBFF_FFBE, 32'hFFFF_FFFC);

        // 6. PC wrap.
        fetch(32'hFFFF_FFFC, 32'h0000_0020, 0);
        check("wrap_pcplus4", PCPlus4, 32'h0);
        consume(0, 0, 0, 32'd0, 32'h0);
        check("wrap_count", FetchCount, 32'd11);
        fetch(32'h0, 32'h0000_0020, 0); consume(0, 0, 0, 32'd0, 32'h4);

        // 7. Reset in WAIT with responses during and after reset.
        wait_req(32'h4);
        IMemGnt = 1'b1;
        @(negedge clk);
        IMemGnt    = 1'b0;
        rst_n      = 1'b0;
        IMemRvalid = 1'b1;
        IMemRdata  = 32'h2008_0005;
        @(negedge clk);
        check("rw_valid_in_rst", 32'(InstrValid), 32'd0);
        check("rw_addr_in_rst", IMemAddr, RESET_PC);
        check("rw_count_in_rst", FetchCount, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        IMemRvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rw_valid_after", 32'(InstrValid), 32'd0);
            check("rw_req_after", 32'(IMemReq), 32'd1);
            check("rw_addr_after", IMemAddr, RESET_PC);
            check("rw_count_after", FetchCount, 32'd0);
            @(negedge clk);
        end
        fetch(32'h0, 32'h2008_0005, 0);
        consume(0, 0, 0, 32'd0, 32'h4);
        check("rw_recover_count", FetchCount, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
